uart_key_decoder: RTL and testbench

- Sits between the UART receiver and the game control block; turns the raw received byte stream into game commands of type state_type.
- Parses single-key commands and ANSI cursor-key escape sequences (ESC [ A..D), with a timeout so a lone ESC never stalls the parser.
- Buffers decoded commands in a small FIFO with a valid/ready handshake, so bursts from a terminal are not lost while the game engine is busy.

---
 rtl/enum_type.sv | 57 +++++
 rtl/uart_key_decoder_cmd_fifo.sv | 69 ++++++
 rtl/uart_key_decoder.sv | 152 +++++++++++++++
 tb/tb_uart_key_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/enum_type.sv
// Shared types for the key decoder: game commands, parser states, protocol bytes
// and the byte-to-command maps.
package enum_type;

  typedef enum logic [3:0] {
    NONE,
    LEFT,
    RIGHT,
    DOWN,
    DROP,
    HOLD,
    ROTATE,
    ROTATE_REV,
    BAR
  } state_type;

  typedef enum logic [1:0] {
    KD_IDLE,
    KD_ESC,
    KD_CSI
  } kd_state_e;

  localparam logic [7:0] BYTE_ESC            = 8'h1B;
  localparam logic [7:0] BYTE_CSI            = 8'h5B;
  localparam int         ESC_TIMEOUT_DEFAULT = 2_000_000;

  // Plain keystrokes, letters accepted in either case.
  function automatic state_type key_to_cmd(input logic [7:0] b);
    state_type c;
    case (b)
      8'h41, 8'h61:        c = LEFT;
      8'h44, 8'h64:        c = RIGHT;
      8'h53, 8'h73:        c = DOWN;
      8'h57, 8'h77, 8'h20: c = DROP;
      8'h43, 8'h63:        c = HOLD;
      8'h58, 8'h78:        c = ROTATE;
      8'h5A, 8'h7A:        c = ROTATE_REV;
      8'h42, 8'h62:        c = BAR;
      default:             c = NONE;
    endcase
    return c;
  endfunction

  // Final byte of an unparameterised CSI cursor sequence (up arrow rotates).
  function automatic state_type cursor_to_cmd(input logic [7:0] b);
    state_type c;
    case (b)
      8'h41:   c = ROTATE;
      8'h42:   c = DOWN;
      8'h43:   c = RIGHT;
      8'h44:   c = LEFT;
      default: c = NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_key_decoder_cmd_fifo.sv
// Generic synchronous FIFO of game commands. Head reads NONE when empty;
// a push into a full FIFO is accepted only if a pop happens in the same cycle.
module cmd_fifo
  import enum_type::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush_i,
  input  logic      push_i,
  input  state_type data_i,
  input  logic      pop_i,
  output state_type data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_type       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? NONE : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_key_decoder.sv
// Turns the UART byte stream into game commands: single keys plus ESC [ A..D
// cursor sequences with an inter-byte timeout, queued in a small command FIFO.
//
// Handshake: cmd_valid means the FIFO head on cmd is a real command; it is
// consumed on any cycle where cmd_valid and cmd_ready are both high. cmd_ready
// has no effect while cmd_valid is low, and cmd is NONE in that case.
module uart_key_decoder
  import enum_type::*;
#(
  parameter int ESC_TIMEOUT = ESC_TIMEOUT_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  input  logic       enable,
  output logic       cmd_valid,
  output state_type  cmd,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic [7:0] drop_cnt,
  output kd_state_e  dbg_state_o
);

  localparam int TW = $clog2(ESC_TIMEOUT + 1);

  kd_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          param_q, param_d;
  state_type     dec_cmd;
  logic          overflow_q;
  logic [7:0]    drop_cnt_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop, drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    param_d = param_q;
    dec_cmd = NONE;
    if (rx_error) begin
      state_d = KD_IDLE;
      timer_d = '0;
      param_d = 1'b0;
    end else begin
      case (state_q)
        KD_IDLE: begin
          if (rx_valid) begin
            if (rx_byte == BYTE_ESC) begin
              state_d = KD_ESC;
              timer_d = TW'(ESC_TIMEOUT);
            end else begin
              dec_cmd = key_to_cmd(rx_byte);
            end
          end
        end
        KD_ESC: begin
          if (rx_valid) begin
            if (rx_byte == BYTE_CSI) begin
              state_d = KD_CSI;
              param_d = 1'b0;
              timer_d = TW'(ESC_TIMEOUT);
            end else if (rx_byte == BYTE_ESC) begin
              timer_d = TW'(ESC_TIMEOUT);
            end else begin
              // Not an escape sequence after all: treat the byte as a plain key.
              state_d = KD_IDLE;
              timer_d = '0;
              dec_cmd = key_to_cmd(rx_byte);
            end
          end else if (timer_q <= TW'(1)) begin
            state_d = KD_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        KD_CSI: begin
          if (rx_valid) begin
            if (rx_byte >= 8'h30 && rx_byte <= 8'h3F) begin
              param_d = 1'b1;
              timer_d = TW'(ESC_TIMEOUT);
            end else begin
              state_d = KD_IDLE;
              timer_d = '0;
              // Parameterised finals (e.g. ctrl-arrows) are swallowed.
              if (rx_byte >= 8'h40 && rx_byte <= 8'h7E && !param_q)
                dec_cmd = cursor_to_cmd(rx_byte);
            end
          end else if (timer_q <= TW'(1)) begin
            state_d = KD_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = KD_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= KD_IDLE;
      timer_q <= '0;
      param_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      param_q <= param_d;
    end
  end

  assign push = enable & (dec_cmd != NONE);
  assign pop  = cmd_valid & cmd_ready;
  assign drop = push & fifo_full & ~pop;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (~enable),
    .push_i  (push),
    .data_i  (dec_cmd),
    .pop_i   (pop),
    .data_o  (cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= drop;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign cmd_valid   = ~fifo_empty;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
// Directed bench for uart_key_decoder: expected commands are queued as bytes are
// sent; a monitor pops and compares on every accepted FIFO head.
module tb_uart_key_decoder;
  import enum_type::*;

  localparam int ESC_TO = 20;

  logic       clk;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       enable;
  logic       cmd_valid;
  state_type  cmd;
  logic       cmd_ready;
  logic       overflow;
  logic [7:0] drop_cnt;
  kd_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  logic [3:0] exp_q[$];

  uart_key_decoder #(
    .ESC_TIMEOUT(ESC_TO),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_err();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got %0d expected none", cmd);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (4'(cmd) !== e) begin
          errors++;
          $display("FAIL cmd_value: got %0d expected %0d", cmd, e);
        end
      end
    end
    if (reset_n && overflow) ovf_seen++;
  end

  initial begin
    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    rx_error  = 1'b0;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    do_reset();

    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'(NONE));
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(KD_IDLE));

    // Single keys with one-cycle latency
    cmd_ready = 1'b1;
    exp_q.push_back(4'(LEFT));
    send_byte(8'h61);
    check("lat_a", 32'(cmd_valid), 32'd1);
    idle(10);
    exp_q.push_back(4'(RIGHT));
    send_byte(8'h44);
    check("lat_D", 32'(cmd_valid), 32'd1);
    idle(10);
    exp_q.push_back(4'(DROP));
    send_byte(8'h20);
    check("lat_space", 32'(cmd_valid), 32'd1);
    idle(10);

    // Cursor sequences
    exp_q.push_back(4'(ROTATE));
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h41);
    exp_q.push_back(4'(LEFT));
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h44);
    idle(5);

    // Timeout, then 'A' is a plain key
    send_byte(8'h1B);
    check("esc_state", 32'(dbg_state), 32'(KD_ESC));
    idle(ESC_TO + 5);
    check("timeout_state", 32'(dbg_state), 32'(KD_IDLE));
    exp_q.push_back(4'(LEFT));
    send_byte(8'h41);
    idle(3);
    exp_q.push_back(4'(DOWN));
    send_byte(8'h1B); send_byte(8'h73);
    idle(3);

    // Parameterised sequence swallowed
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h31);
    send_byte(8'h3B); send_byte(8'h35);
    check("csi_state", 32'(dbg_state), 32'(KD_CSI));
    send_byte(8'h43);
    check("param_state", 32'(dbg_state), 32'(KD_IDLE));
    exp_q.push_back(4'(ROTATE));
    send_byte(8'h78);
    idle(3);

    // rx_error aborts a CSI
    send_byte(8'h1B); send_byte(8'h5B);
    send_err();
    check("err_state", 32'(dbg_state), 32'(KD_IDLE));
    exp_q.push_back(4'(LEFT));
    send_byte(8'h41);
    idle(3);

    // Overflow
    cmd_ready = 1'b0;
    ovf_seen  = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(4'(DROP));
      send_byte(8'h77);
      tick();
    end
    idle(2);
    check("ovf_pulses", 32'(ovf_seen), 32'd2);
    check("drop_cnt", 32'(drop_cnt), 32'd2);
    check("full_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_done", 32'(exp_q.size()), 32'd0);
    idle(1);
    check("drain_cmd", 32'(cmd), 32'(NONE));
    check("drain_valid", 32'(cmd_valid), 32'd0);

    // Flush via enable
    cmd_ready = 1'b0;
    send_byte(8'h63); send_byte(8'h7A);
    check("pre_flush_valid", 32'(cmd_valid), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("flush_valid", 32'(cmd_valid), 32'd0);
    check("flush_cmd", 32'(cmd), 32'(NONE));
    cmd_ready = 1'b1;
    idle(2);

    // Reset mid-CSI
    send_byte(8'h1B); send_byte(8'h5B);
    do_reset();
    check("rst2_state", 32'(dbg_state), 32'(KD_IDLE));
    check("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.push_back(4'(BAR));
    send_byte(8'h42);
    idle(5);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
